// File: rtl/alu_writeback.sv
// alu_writeback: registered result/writeback stage behind the combinational ALU.
// It captures the ALU results C/D and the Low/Negative/Zero flags. It drives the
// register-file write port and holds the processor flag register.
// A wide (MUL high-half) result becomes two back-to-back writes: C to dest,
// then D to dest+1. The address wraps modulo 2^REG_AW.
//
// Optional feature macro: ALU_WB_R0_GUARD_EN
//   defined   -> any write addressed to register 0 keeps rf_we low. rf_waddr,
//                rf_wdata, the state and the flags still update as usual.
//   undefined -> register 0 is written like any other register.
//
// Handshake: a result is taken on a rising clk edge when in_valid && in_ready.
// in_ready is high only in IDLE. While in_ready is low, in_valid is ignored and
// upstream must hold its data until in_ready returns. No output depends
// combinationally on any in_* input.
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_d,
  input  logic              in_low,
  input  logic              in_neg,
  input  logic              in_zero,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_wr_en,
  input  logic              in_wide,
  input  logic              in_flag_en,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_low,
  output logic              flag_neg,
  output logic              flag_zero,
  output logic              busy
);

  // IDLE accepts new results; WR_HI issues the pending high-half write.
  typedef enum logic {
    IDLE  = 1'b0,
    WR_HI = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                flag_low_q, flag_low_d;
  logic                flag_neg_q, flag_neg_d;
  logic                flag_zero_q, flag_zero_d;
  logic [DATA_W-1:0]   hi_data_q, hi_data_d;
  logic [REG_AW-1:0]   hi_addr_q, hi_addr_d;
  logic                accept;

  // Decide whether a write to the given address may raise the strobe.
  function automatic logic write_allowed(input logic [REG_AW-1:0] addr);
`ifdef ALU_WB_R0_GUARD_EN
    return (addr != '0);
`else
    return (addr == addr);
`endif
  endfunction

  assign accept = in_valid && (state_q == IDLE);

  // Next-state, write-port and flag update logic; everything holds by default.
  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    flag_low_d  = flag_low_q;
    flag_neg_d  = flag_neg_q;
    flag_zero_d = flag_zero_q;
    hi_data_d   = hi_data_q;
    hi_addr_d   = hi_addr_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_wr_en) begin
            rf_we_d    = write_allowed(in_dest);
            rf_waddr_d = in_dest;
            rf_wdata_d = in_c;
            // in_wide only matters for a result that is actually written.
            if (in_wide) begin
              hi_data_d = in_d;
              hi_addr_d = in_dest + REG_AW'(1);
              state_d   = WR_HI;
            end
          end
          // The three flags always load together.
          if (in_flag_en) begin
            flag_low_d  = in_low;
            flag_neg_d  = in_neg;
            flag_zero_d = in_zero;
          end
        end
      end
      WR_HI: begin
        rf_we_d    = write_allowed(hi_addr_q);
        rf_waddr_d = hi_addr_q;
        rf_wdata_d = hi_data_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any pending high-half write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      flag_low_q  <= 1'b0;
      flag_neg_q  <= 1'b0;
      flag_zero_q <= 1'b0;
      hi_data_q   <= '0;
      hi_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      flag_low_q  <= flag_low_d;
      flag_neg_q  <= flag_neg_d;
      flag_zero_q <= flag_zero_d;
      hi_data_q   <= hi_data_d;
      hi_addr_q   <= hi_addr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == WR_HI);
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign flag_low  = flag_low_q;
  assign flag_neg  = flag_neg_q;
  assign flag_zero = flag_zero_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: a linear sequence of steps with
// hand-computed expected values, checked by immediate assertions.
module tb_alu_writeback;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

`ifdef ALU_WB_R0_GUARD_EN
  localparam logic R0_WE = 1'b0;
`else
  localparam logic R0_WE = 1'b1;
`endif

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_c;
  logic [DATA_W-1:0] in_d;
  logic              in_low;
  logic              in_neg;
  logic              in_zero;
  logic [REG_AW-1:0] in_dest;
  logic              in_wr_en;
  logic              in_wide;
  logic              in_flag_en;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flag_low;
  logic              flag_neg;
  logic              flag_zero;
  logic              busy;

  int tests_run;
  int tests_failed;

  alu_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_c       (in_c),
    .in_d       (in_d),
    .in_low     (in_low),
    .in_neg     (in_neg),
    .in_zero    (in_zero),
    .in_dest    (in_dest),
    .in_wr_en   (in_wr_en),
    .in_wide    (in_wide),
    .in_flag_en (in_flag_en),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flag_low   (flag_low),
    .flag_neg   (flag_neg),
    .flag_zero  (flag_zero),
    .busy       (busy)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one result onto the input bus (in_valid asserted).
  task automatic drive(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic [REG_AW-1:0] dest, input logic wr_en,
                       input logic wide, input logic flag_en,
                       input logic low, input logic neg, input logic zero);
    in_valid   = 1'b1;
    in_c       = c;
    in_d       = d;
    in_dest    = dest;
    in_wr_en   = wr_en;
    in_wide    = wide;
    in_flag_en = flag_en;
    in_low     = low;
    in_neg     = neg;
    in_zero    = zero;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_wr_en   = 1'b0;
    in_wide    = 1'b0;
    in_flag_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(rf_we),     32'h0);
    chk({tag, "_waddr"}, 32'(rf_waddr),  32'h0);
    chk({tag, "_wdata"}, 32'(rf_wdata),  32'h0);
    chk({tag, "_flags"}, 32'({flag_low, flag_neg, flag_zero}), 32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    in_c         = '0;
    in_d         = '0;
    in_dest      = '0;
    in_low       = 1'b0;
    in_neg       = 1'b0;
    in_zero      = 1'b0;
    idle_inputs();

    // Reset state
    #1;
    chk_all_zero("reset");
    chk("reset_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write with Negative flag
    @(negedge clk);
    drive(16'h1234, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("single_we",    32'(rf_we),    32'h1);
    chk("single_waddr", 32'(rf_waddr), 32'h3);
    chk("single_wdata", 32'(rf_wdata), 32'h1234);
    chk("single_flags", 32'({flag_low, flag_neg, flag_zero}), 32'b010);
    tick();
    chk("single_we_off", 32'(rf_we),   32'h0);
    chk("single_hold_addr", 32'(rf_waddr), 32'h3);
    chk("single_hold_data", 32'(rf_wdata), 32'h1234);

    // Wide MUL result; in_valid raised during WR_HI must be ignored
    drive(16'h0001, 16'hFFFF, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'hAAAA, 16'hBBBB, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wide_lo_we",    32'(rf_we),    32'h1);
    chk("wide_lo_waddr", 32'(rf_waddr), 32'h6);
    chk("wide_lo_wdata", 32'(rf_wdata), 32'h0001);
    chk("wide_lo_ready", 32'(in_ready), 32'h0);
    chk("wide_lo_busy",  32'(busy),     32'h1);
    chk("wide_flags_kept", 32'({flag_low, flag_neg, flag_zero}), 32'b010);
    tick();
    idle_inputs();
    chk("wide_hi_we",    32'(rf_we),    32'h1);
    chk("wide_hi_waddr", 32'(rf_waddr), 32'h7);
    chk("wide_hi_wdata", 32'(rf_wdata), 32'hFFFF);
    chk("wide_hi_ready", 32'(in_ready), 32'h1);
    chk("wide_hi_busy",  32'(busy),     32'h0);
    tick();
    chk("wrhi_ignored_we",   32'(rf_we),    32'h0);
    chk("wrhi_ignored_addr", 32'(rf_waddr), 32'h7);

    // Flags cleared, then in_flag_en=0 must not touch them
    drive(16'h0000, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("clear_flags", 32'({flag_low, flag_neg, flag_zero}), 32'b000);
    chk("nowr_we",     32'(rf_we),    32'h0);
    chk("nowr_ready",  32'(in_ready), 32'h1);
    drive(16'h5555, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("flaghold_flags", 32'({flag_low, flag_neg, flag_zero}), 32'b000);
    chk("flaghold_we",    32'(rf_we),    32'h1);
    chk("flaghold_waddr", 32'(rf_waddr), 32'h2);
    chk("flaghold_wdata", 32'(rf_wdata), 32'h5555);

    // All three flags load together
    drive(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    chk("flagload", 32'({flag_low, flag_neg, flag_zero}), 32'b101);

    // Back-to-back single writes
    drive(16'h0404, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_0_we",   32'(rf_we),    32'h1);
    chk("b2b_0_addr", 32'(rf_waddr), 32'h4);
    drive(16'h0505, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("b2b_1_we",   32'(rf_we),    32'h1);
    chk("b2b_1_addr", 32'(rf_waddr), 32'h5);
    chk("b2b_1_data", 32'(rf_wdata), 32'h0505);

    // Wide write from register 15 wraps to register 0
    drive(16'h0F0F, 16'hF0F0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("wrap_lo_we",   32'(rf_we),    32'h1);
    chk("wrap_lo_addr", 32'(rf_waddr), 32'hF);
    tick();
    chk("wrap_hi_we",   32'(rf_we),    32'(R0_WE));
    chk("wrap_hi_addr", 32'(rf_waddr), 32'h0);
    chk("wrap_hi_data", 32'(rf_wdata), 32'hF0F0);
    chk("wrap_ready",   32'(in_ready), 32'h1);

    // Narrow write straight to register 0
    drive(16'h0BAD, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("r0_we",   32'(rf_we),    32'(R0_WE));
    chk("r0_data", 32'(rf_wdata), 32'h0BAD);

    // Reset while the high write is pending
    drive(16'h1111, 16'h2222, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("rst_pre_busy",  32'(busy), 32'h1);
    chk("rst_pre_flags", 32'({flag_low, flag_neg, flag_zero}), 32'b111);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_we",   32'(rf_we), 32'h0);
    chk("post_rst_busy", 32'(busy),  32'h0);
    tick();
    chk("post_rst_we2",   32'(rf_we),    32'h0);
    chk("post_rst_addr",  32'(rf_waddr), 32'h0);
    chk("post_rst_flags", 32'({flag_low, flag_neg, flag_zero}), 32'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
